// File: rtl/vlc_tz_decoder.sv
// Bit-serial total_zeros VLC decoder: one bit per cycle in, {value, length, error} out.
// Optional symbol/bit statistics counters are enabled with VLC_TZ_DECODER_STATS_EN.
module vlc_tz_decoder #(
  parameter int VAL_W   = 4,
  parameter int LEN_W   = 4,
  parameter int MAX_LEN = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_tbl,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             bit_in,
  output logic             val_valid,
  input  logic             val_ready,
  output logic [VAL_W-1:0] val_out,
  output logic [LEN_W-1:0] len_out,
  output logic             err_out
`ifdef VLC_TZ_DECODER_STATS_EN
  ,
  output logic [15:0]      sym_cnt,
  output logic [19:0]      bit_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  state_t             state, state_nxt;
  logic               tbl;
  logic [MAX_LEN-2:0] prefix;
  logic [LEN_W-1:0]   cnt;
  logic [MAX_LEN-1:0] code;
  logic [LEN_W-1:0]   n;
  logic               hit, err_hit;
  logic [VAL_W-1:0]   val_hit;

  // Bits above the current code length are always zero because prefix is cleared per command.
  function automatic logic [VAL_W+1:0] decode_code(input logic t,
                                                   input logic [MAX_LEN-1:0] c,
                                                   input logic [LEN_W-1:0] len);
    int               ci, ni;
    logic             h, e;
    logic [VAL_W-1:0] v;
    ci = int'(c);
    ni = int'(len);
    h  = 1'b0;
    e  = 1'b0;
    v  = '0;
    if (!t) begin
      if (ni == 1 && ci == 1) begin
        h = 1'b1;
      end else if (ni >= 3 && ni <= MAX_LEN && c[1] && (ci >> 2) == 0) begin
        h = 1'b1;
        v = VAL_W'(2 * (ni - 2) - (ci % 2));
      end else if (ni == MAX_LEN) begin
        h = 1'b1;
        e = (ci == 0);
        v = e ? '0 : VAL_W'(15);
      end
    end else begin
      if (ni == 3 && ci >= 3) begin
        h = 1'b1;
        v = VAL_W'(7 - ci);
      end else if (ni == 4 && ci >= 2 && ci <= 5) begin
        h = 1'b1;
        v = VAL_W'(10 - ci);
      end else if (ni == 5 && ci >= 2 && ci <= 3) begin
        h = 1'b1;
        v = VAL_W'(12 - ci);
      end else if (ni == 6 && ci <= 3) begin
        h = 1'b1;
        v = VAL_W'(14 - ci);
      end
    end
    return {h, e, v};
  endfunction

  assign code = {prefix, bit_in};
  assign n    = cnt + 1'b1;
  assign {hit, err_hit, val_hit} = decode_code(tbl, code, n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    bit_ready = 1'b0;
    val_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        bit_ready = 1'b1;
        if (bit_valid && hit) state_nxt = OUT;
      end
      OUT: begin
        val_valid = 1'b1;
        if (val_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl     <= 1'b0;
      prefix  <= '0;
      cnt     <= '0;
      val_out <= '0;
      len_out <= '0;
      err_out <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        tbl    <= cmd_tbl;
        prefix <= '0;
        cnt    <= '0;
      end
      if (state == SHIFT && bit_valid) begin
        prefix <= code[MAX_LEN-2:0];
        cnt    <= n;
        if (hit) begin
          val_out <= val_hit;
          len_out <= n;
          err_out <= err_hit;
        end
      end
    end
  end

`ifdef VLC_TZ_DECODER_STATS_EN
  // Counters advance on every delivered symbol, including illegal-code reports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt <= '0;
      bit_cnt <= '0;
    end else if (val_valid && val_ready) begin
      sym_cnt <= sym_cnt + 16'd1;
      bit_cnt <= bit_cnt + 20'(len_out);
    end
  end
`endif

endmodule

// File: tb/tb_vlc_tz_decoder.sv
// Randomized + directed bench for vlc_tz_decoder with a code-table reference model.
// Drives and samples on the falling edge; the model predicts handshakes for the next rising edge.
module tb_vlc_tz_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_tbl, bit_valid, bit_in, val_ready;
  logic       cmd_ready, bit_ready, val_valid, err_out;
  logic [3:0] val_out, len_out;
`ifdef VLC_TZ_DECODER_STATS_EN
  logic [15:0] sym_cnt;
  logic [19:0] bit_cnt;
`endif

  vlc_tz_decoder dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tbl(cmd_tbl),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_in(bit_in),
    .val_valid(val_valid), .val_ready(val_ready),
    .val_out(val_out), .len_out(len_out), .err_out(err_out)
`ifdef VLC_TZ_DECODER_STATS_EN
    , .sym_cnt(sym_cnt), .bit_cnt(bit_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit tbl;
    int val;
    int len;
    bit err;
  } sym_t;

  int t1_code [15] = '{7, 6, 5, 4, 3, 5, 4, 3, 2, 3, 2, 3, 2, 1, 0};
  int t1_len  [15] = '{3, 3, 3, 3, 3, 4, 4, 4, 4, 5, 5, 6, 6, 6, 6};

  int   checks = 0;
  int   errors = 0;
  sym_t cmd_q[$];
  sym_t exp_q[$];
  sym_t obs_q[$];
  bit   bit_q[$];
  int   phase, taken, gap_cfg, stall_cfg, gap_cnt, stall_cnt;
  int   model_sym, model_bits;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Encoder side of the tables: builds the bitstream and the expected symbol.
  task automatic add_sym(input bit tbl, input int v, input bit err);
    sym_t s;
    int   k;
    s.tbl = tbl; s.val = v; s.err = err;
    if (!tbl) begin
      if (err) begin
        for (int i = 0; i < 9; i++) bit_q.push_back(1'b0);
        s.len = 9; s.val = 0;
      end else if (v == 0) begin
        bit_q.push_back(1'b1);
        s.len = 1;
      end else if (v == 15) begin
        for (int i = 0; i < 8; i++) bit_q.push_back(1'b0);
        bit_q.push_back(1'b1);
        s.len = 9;
      end else begin
        k = (v + 1) / 2;
        for (int i = 0; i < k; i++) bit_q.push_back(1'b0);
        bit_q.push_back(1'b1);
        bit_q.push_back(v % 2 == 1);
        s.len = k + 2;
      end
    end else begin
      s.err = 1'b0;
      s.len = t1_len[v];
      for (int i = s.len - 1; i >= 0; i--) bit_q.push_back(((t1_code[v] >> i) & 1) == 1);
    end
    cmd_q.push_back(s);
  endtask

  task automatic step();
    sym_t o;
    @(negedge clk);
    check("cmd_ready", int'(cmd_ready), int'(phase == 0));
    check("bit_ready", int'(bit_ready), int'(phase == 1));
    check("val_valid", int'(val_valid), int'(phase == 2));
    if (phase == 2 && exp_q.size() > 0) begin
      check("val_out", int'(val_out), exp_q[0].val);
      check("len_out", int'(len_out), exp_q[0].len);
      check("err_out", int'(err_out), int'(exp_q[0].err));
    end
`ifdef VLC_TZ_DECODER_STATS_EN
    check("sym_cnt", int'(sym_cnt), model_sym % 65536);
    check("bit_cnt", int'(bit_cnt), model_bits % (1 << 20));
`endif
    cmd_valid = (cmd_q.size() > 0) && ($urandom_range(0, 3) != 0);
    cmd_tbl   = (cmd_q.size() > 0) ? cmd_q[0].tbl : 1'($urandom);
    if (gap_cnt > 0) begin
      bit_valid = 1'b0;
      gap_cnt--;
    end else if (bit_q.size() == 0) begin
      bit_valid = 1'b0;
    end else begin
      bit_valid = (gap_cfg >= 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    bit_in = (bit_q.size() > 0) ? bit_q[0] : 1'($urandom);
    if (phase == 2) begin
      if (stall_cnt > 0) begin
        val_ready = 1'b0;
        stall_cnt--;
      end else begin
        val_ready = (stall_cfg >= 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
    end else begin
      val_ready = 1'($urandom);
    end
    case (phase)
      0: if (cmd_valid) begin
        exp_q.push_back(cmd_q.pop_front());
        phase = 1;
        taken = 0;
      end
      1: if (bit_valid) begin
        void'(bit_q.pop_front());
        taken++;
        if (gap_cfg > 0) gap_cnt = gap_cfg;
        if (taken == exp_q[0].len) begin
          phase = 2;
          stall_cnt = (stall_cfg > 0) ? stall_cfg : 0;
        end
      end
      default: if (val_ready) begin
        o.tbl = exp_q[0].tbl; o.val = int'(val_out); o.len = int'(len_out); o.err = err_out;
        obs_q.push_back(o);
        model_sym++;
        model_bits += exp_q[0].len;
        void'(exp_q.pop_front());
        phase = 0;
      end
    endcase
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((cmd_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("run_timeout", n, -1);
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_bit_ready", int'(bit_ready), 0);
    check("rst_val_valid", int'(val_valid), 0);
    check("rst_val_out", int'(val_out), 0);
    check("rst_len_out", int'(len_out), 0);
    check("rst_err_out", int'(err_out), 0);
    bit_q.delete(); cmd_q.delete(); exp_q.delete();
    phase = 0; taken = 0; gap_cnt = 0; stall_cnt = 0;
    model_sym = 0; model_bits = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_obs(input int i, input int v, input int l, input int e);
    if (i < obs_q.size()) begin
      check("obs_val", obs_q[i].val, v);
      check("obs_len", obs_q[i].len, l);
      check("obs_err", int'(obs_q[i].err), e);
    end else begin
      check("obs_missing", obs_q.size(), i + 1);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_tbl = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; val_ready = 1'b0;
    gap_cfg = 0; stall_cfg = 0;
    do_reset();

    // Shortest code, longest table-0 codes, longest table-1 code.
    obs_q.delete();
    add_sym(0, 0, 0); add_sym(0, 15, 0); add_sym(1, 14, 0);
    run(200);
    chk_obs(0, 0, 1, 0); chk_obs(1, 15, 9, 0); chk_obs(2, 14, 6, 0);
`ifdef VLC_TZ_DECODER_STATS_EN
    check("stats_sym_lit", int'(sym_cnt), 3);
    check("stats_bit_lit", int'(bit_cnt), 16);
`endif

    // 9-bit code with two bubble cycles after every bit.
    obs_q.delete();
    gap_cfg = 2;
    add_sym(0, 13, 0);
    run(200);
    chk_obs(0, 13, 9, 0);
    gap_cfg = 0;

    // Illegal code followed by a normal one.
    obs_q.delete();
    add_sym(0, 0, 1); add_sym(0, 1, 0);
    run(200);
    chk_obs(0, 0, 9, 1); chk_obs(1, 1, 3, 0);

    // Whole table 1 with 3-cycle output stalls.
    obs_q.delete();
    stall_cfg = 3;
    for (int v = 0; v < 15; v++) add_sym(1, v, 0);
    run(1000);
    for (int v = 0; v < 15; v++) chk_obs(v, v, t1_len[v], 0);
    stall_cfg = 0;

    // Reset after four bits of a table-0 code, then a clean decode.
    add_sym(0, 0, 1);
    n = 0;
    while (!(phase == 1 && taken == 4) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("midreset_timeout", n, -1);
    do_reset();
    obs_q.delete();
    add_sym(0, 2, 0);
    run(200);
    chk_obs(0, 2, 3, 0);

    // Random symbols, random bubbles and stalls.
    gap_cfg = -1; stall_cfg = -1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) add_sym(1, $urandom_range(0, 14), 0);
      else if ($urandom_range(0, 15) == 0) add_sym(0, 0, 1);
      else add_sym(0, $urandom_range(0, 15), 0);
    end
    run(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
